if_prefetch_queue: RTL and testbench

- Parametrised instruction-fetch front end. It issues sequential PC requests to the I-cache and buffers returned instructions with their PCs in a DEPTH-entry queue.
- Decode pops entries through a valid/ready handshake. Branch/jump/jr resolution downstream drives a redirect that flushes the queue and restarts fetch at the target.
- Sits between the I-cache and the IF/ID pipeline register. It replaces the single-PC fetch register.

---
 rtl/if_pkg.sv | 21 ++
 rtl/fetch_fifo.sv | 87 ++++++++
 rtl/if_prefetch_queue.sv | 122 ++++++++++++
 tb/tb_if_prefetch_queue.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/if_pkg.sv
// Shared types for the instruction-fetch front end: fetch FSM states and the
// default queue entry layout (PC plus instruction word).
package if_pkg;

  typedef enum logic [1:0] {
    FETCH,
    MISS,
    FULL
  } fetch_state_e;

  localparam int ENTRY_ADDR_W = 32;
  localparam int ENTRY_INST_W = 32;

  typedef struct packed {
    logic [ENTRY_ADDR_W-1:0] pc;
    logic [ENTRY_INST_W-1:0] inst;
  } fetch_entry_t;

  localparam int PC_STEP = 4;

endpackage

// File: rtl/fetch_fifo.sv
// DEPTH-entry queue with push/pop/flush and a registered head; pushed data reaches head_dat one cycle later.
// Push is dropped when full or flushing, pop is ignored when empty; flush wins over both.
module fetch_fifo
  import if_pkg::*;
#(
  parameter int  DEPTH   = 4,
  parameter type entry_t = fetch_entry_t
) (
  input  logic                   clk,
  input  logic                   rst_b,
  input  logic                   flush,
  input  logic                   push_vld,
  input  entry_t                 push_dat,
  input  logic                   pop_rdy,
  output logic                   head_vld,
  output entry_t                 head_dat,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int QW    = PTR_W + 1;
  localparam logic [QW-1:0] FULL_CNT = QW'(DEPTH);

  entry_t           mem_q [DEPTH];
  entry_t           mem_d [DEPTH];
  entry_t           head_q, head_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [QW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  assign do_push = push_vld & ~flush & (count_q != FULL_CNT);
  assign do_pop  = pop_rdy & ~flush & (count_q != '0);

  always_comb begin
    mem_d    = mem_q;
    head_d   = head_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q] = push_dat;
        wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + QW'(1);
        2'b01:   count_d = count_q - QW'(1);
        default: count_d = count_q;
      endcase
      // Head is reloaded from post-write storage so a push into an empty queue shows next cycle.
      if (count_d != '0) begin
        head_d = mem_d[rd_ptr_d];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      head_q   <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      head_q   <= head_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign head_vld = (count_q != '0);
  assign head_dat = head_q;
  assign count    = count_q;

endmodule

// File: rtl/if_prefetch_queue.sv
// Sequential I-cache fetcher feeding a DEPTH-entry instruction queue; a hit appears on out_* one cycle later.
// Fetch pauses while the queue is full or on a miss; a redirect flushes the queue and restarts at the target.
module if_prefetch_queue
  import if_pkg::*;
#(
  parameter int                ADDR_W   = 32,
  parameter int                INST_W   = 32,
  parameter int                DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int                CNT_W    = 32
) (
  input  logic                   clk,
  input  logic                   rst_b,
  input  logic                   cache_en,
  output logic                   icache_req,
  output logic [ADDR_W-1:0]      icache_addr,
  input  logic                   icache_hit,
  input  logic [INST_W-1:0]      icache_inst,
  input  logic                   redirect_valid,
  input  logic [ADDR_W-1:0]      redirect_pc,
  output logic                   out_valid,
  output logic [INST_W-1:0]      out_inst,
  output logic [ADDR_W-1:0]      out_pc,
  input  logic                   out_ready,
  output logic [$clog2(DEPTH):0] queue_count,
  output logic [CNT_W-1:0]       stall_cycles
);

  localparam int QCNT_W = $clog2(DEPTH) + 1;
  localparam logic [QCNT_W-1:0] FULL_CNT = QCNT_W'(DEPTH);

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [INST_W-1:0] inst;
  } entry_t;

  fetch_state_e      state_q, state_d;
  logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
  logic [CNT_W-1:0]  stall_q, stall_d;
  logic              hit_eff, push, pop, miss;
  logic [QCNT_W-1:0] count, count_nxt;
  entry_t            wr_entry, head;
  logic              head_vld;

  assign icache_req  = (state_q != FULL);
  assign icache_addr = fetch_pc_q;
  assign hit_eff     = icache_hit | ~cache_en;
  assign push        = icache_req & hit_eff & ~redirect_valid;
  assign pop         = head_vld & out_ready;
  assign miss        = icache_req & ~hit_eff;
  assign count_nxt   = count + QCNT_W'(push) - QCNT_W'(pop);
  assign wr_entry    = '{pc: fetch_pc_q, inst: icache_inst};

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    stall_d    = stall_q;

    if (miss && (stall_q != '1)) begin
      stall_d = stall_q + CNT_W'(1);
    end

    if (redirect_valid) begin
      state_d    = FETCH;
      fetch_pc_d = redirect_pc & ~ADDR_W'(3);
    end else begin
      if (push) begin
        fetch_pc_d = fetch_pc_q + ADDR_W'(PC_STEP);
      end
      case (state_q)
        FETCH, MISS: begin
          if (push) begin
            state_d = (count_nxt == FULL_CNT) ? FULL : FETCH;
          end else if (miss) begin
            state_d = MISS;
          end
        end
        // No bypass: the slot freed by a pop is refilled no earlier than the next cycle.
        FULL: begin
          if (pop) begin
            state_d = FETCH;
          end
        end
        default: state_d = FETCH;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q    <= FETCH;
      fetch_pc_q <= RESET_PC;
      stall_q    <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      stall_q    <= stall_d;
    end
  end

  fetch_fifo #(
    .DEPTH   (DEPTH),
    .entry_t (entry_t)
  ) u_fifo (
    .clk      (clk),
    .rst_b    (rst_b),
    .flush    (redirect_valid),
    .push_vld (push),
    .push_dat (wr_entry),
    .pop_rdy  (pop),
    .head_vld (head_vld),
    .head_dat (head),
    .count    (count)
  );

  assign out_valid    = head_vld;
  assign out_inst     = head.inst;
  assign out_pc       = head.pc;
  assign queue_count  = count;
  assign stall_cycles = stall_q;

endmodule

// File: tb/tb_if_prefetch_queue.sv
// Directed bench for if_prefetch_queue: stimulus queues expected PCs, negedge monitors pop and compare.
// Instance a: 4-bit stall counter; instance b: RESET_PC near the top of the address space.
module tb_if_prefetch_queue;

  localparam int AW = 32;
  localparam int IW = 32;
  localparam int DEPTH = 4;
  localparam int CW = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_b;

  logic          a_cache_en, a_req, a_hit, a_redir_vld, a_vld, a_rdy;
  logic [AW-1:0] a_addr, a_redir_pc, a_pc;
  logic [IW-1:0] a_inst_in, a_inst;
  logic [2:0]    a_cnt;
  logic [CW-1:0] a_stall;

  logic          b_cache_en, b_req, b_hit, b_redir_vld, b_vld, b_rdy;
  logic [AW-1:0] b_addr, b_redir_pc, b_pc;
  logic [IW-1:0] b_inst_in, b_inst;
  logic [2:0]    b_cnt;
  logic [31:0]   b_stall;

  function automatic logic [IW-1:0] inst_of(input logic [AW-1:0] pc);
    return {pc[15:0], pc[31:16]} ^ 32'h1357_9BDF;
  endfunction

  assign a_inst_in = inst_of(a_addr);
  assign b_inst_in = inst_of(b_addr);

  if_prefetch_queue #(
    .ADDR_W(AW), .INST_W(IW), .DEPTH(DEPTH), .RESET_PC(32'h0), .CNT_W(CW)
  ) dut_a (
    .clk(clk), .rst_b(rst_b), .cache_en(a_cache_en),
    .icache_req(a_req), .icache_addr(a_addr), .icache_hit(a_hit), .icache_inst(a_inst_in),
    .redirect_valid(a_redir_vld), .redirect_pc(a_redir_pc),
    .out_valid(a_vld), .out_inst(a_inst), .out_pc(a_pc), .out_ready(a_rdy),
    .queue_count(a_cnt), .stall_cycles(a_stall)
  );

  if_prefetch_queue #(
    .ADDR_W(AW), .INST_W(IW), .DEPTH(DEPTH), .RESET_PC(32'hFFFF_FFF8), .CNT_W(32)
  ) dut_b (
    .clk(clk), .rst_b(rst_b), .cache_en(b_cache_en),
    .icache_req(b_req), .icache_addr(b_addr), .icache_hit(b_hit), .icache_inst(b_inst_in),
    .redirect_valid(b_redir_vld), .redirect_pc(b_redir_pc),
    .out_valid(b_vld), .out_inst(b_inst), .out_pc(b_pc), .out_ready(b_rdy),
    .queue_count(b_cnt), .stall_cycles(b_stall)
  );

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%h, expected 0x%h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [AW-1:0] a_exp_q[$];
  logic [AW-1:0] b_exp_q[$];
  logic [AW-1:0] a_e, b_e;

  always @(negedge clk) begin
    if (rst_b && a_vld && a_rdy) begin
      if (a_exp_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL a_unexpected_pop: got pc 0x%h, no entry expected", a_pc);
      end else begin
        a_e = a_exp_q.pop_front();
        chk("a_out_pc", a_pc, a_e);
        chk("a_out_inst", a_inst, inst_of(a_e));
      end
    end
  end

  always @(negedge clk) begin
    if (rst_b && b_vld && b_rdy && b_exp_q.size() > 0) begin
      b_e = b_exp_q.pop_front();
      chk("b_out_pc", b_pc, b_e);
      chk("b_out_inst", b_inst, inst_of(b_e));
    end
  end

  initial begin
    rst_b = 1'b0;
    a_cache_en = 1'b0; a_hit = 1'b0; a_redir_vld = 1'b0; a_redir_pc = '0; a_rdy = 1'b1;
    b_cache_en = 1'b0; b_hit = 1'b0; b_redir_vld = 1'b0; b_redir_pc = '0; b_rdy = 1'b1;
    b_exp_q = {32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_0000, 32'h0000_0004};
    tick();
    tick();

    chk("rst_out_valid", 32'(a_vld), 32'h0);
    chk("rst_count", 32'(a_cnt), 32'h0);
    chk("rst_out_pc", a_pc, 32'h0);
    chk("rst_out_inst", a_inst, 32'h0);
    chk("rst_stall", 32'(a_stall), 32'h0);
    chk("rst_addr", a_addr, 32'h0);
    chk("rst_b_addr", b_addr, 32'hFFFF_FFF8);
    rst_b = 1'b1;

    // Streaming with cache disabled: one entry per cycle, request never drops.
    for (int i = 0; i < 8; i++) begin
      chk("t1_req", 32'(a_req), 32'h1);
      chk("t1_addr", a_addr, 32'(4 * i));
      a_exp_q.push_back(32'(4 * i));
      tick();
    end
    a_redir_vld = 1'b1; a_redir_pc = 32'h0;
    tick();
    a_redir_vld = 1'b0;
    chk("t1_flush_count", 32'(a_cnt), 32'h0);
    chk("t1_flush_valid", 32'(a_vld), 32'h0);
    chk("t1_flush_addr", a_addr, 32'h0);
    chk("t1_drained", 32'(a_exp_q.size()), 32'h0);

    // Fill to FULL with decode stalled, then release one slot.
    a_cache_en = 1'b1; a_hit = 1'b1; a_rdy = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("t2_addr", a_addr, 32'(4 * i));
      a_exp_q.push_back(32'(4 * i));
      tick();
    end
    chk("t2_full_req", 32'(a_req), 32'h0);
    chk("t2_full_count", 32'(a_cnt), 32'h4);
    chk("t2_head_pc", a_pc, 32'h0);
    tick();
    chk("t2_hold_req", 32'(a_req), 32'h0);
    chk("t2_hold_addr", a_addr, 32'h10);
    a_rdy = 1'b1;
    tick();
    a_rdy = 1'b0;
    chk("t2_resume_req", 32'(a_req), 32'h1);
    chk("t2_resume_addr", a_addr, 32'h10);
    chk("t2_pop_count", 32'(a_cnt), 32'h3);
    a_exp_q.push_back(32'h10);
    tick();
    chk("t2_refull_count", 32'(a_cnt), 32'h4);
    chk("t2_refull_req", 32'(a_req), 32'h0);
    a_rdy = 1'b1;
    tick();
    a_rdy = 1'b0;

    // Redirect with three queued entries, a same-cycle hit and a same-cycle pop.
    chk("t4_pre_count", 32'(a_cnt), 32'h3);
    a_redir_vld = 1'b1; a_redir_pc = 32'h103; a_rdy = 1'b1;
    tick();
    a_redir_vld = 1'b0; a_rdy = 1'b0;
    a_exp_q.delete();
    chk("t4_count", 32'(a_cnt), 32'h0);
    chk("t4_valid", 32'(a_vld), 32'h0);
    chk("t4_addr", a_addr, 32'h100);
    chk("t4_req", 32'(a_req), 32'h1);
    chk("t4_stall", 32'(a_stall), 32'h0);
    a_redir_vld = 1'b1; a_redir_pc = 32'h8;
    tick();
    a_redir_vld = 1'b0;
    chk("t3_start_addr", a_addr, 32'h8);

    // Five-cycle miss at PC 8, then streaming, then a long miss to saturate the counter.
    a_rdy = 1'b1; a_hit = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("t3_miss_addr", a_addr, 32'h8);
      chk("t3_miss_req", 32'(a_req), 32'h1);
      tick();
    end
    chk("t3_stall", 32'(a_stall), 32'h5);
    a_hit = 1'b1;
    a_exp_q.push_back(32'h8);
    tick();
    chk("t3_next_addr", a_addr, 32'hC);
    a_exp_q.push_back(32'hC);
    tick();
    a_exp_q.push_back(32'h10);
    tick();
    a_hit = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
    end
    chk("t5_stall_sat", 32'(a_stall), 32'hF);
    chk("t5_addr", a_addr, 32'h14);
    chk("t5_count", 32'(a_cnt), 32'h0);
    chk("t5_drained", 32'(a_exp_q.size()), 32'h0);

    // Asynchronous reset while in MISS.
    rst_b = 1'b0;
    #1;
    chk("rst2_out_valid", 32'(a_vld), 32'h0);
    chk("rst2_count", 32'(a_cnt), 32'h0);
    chk("rst2_out_pc", a_pc, 32'h0);
    chk("rst2_out_inst", a_inst, 32'h0);
    chk("rst2_stall", 32'(a_stall), 32'h0);
    chk("rst2_addr", a_addr, 32'h0);
    tick();
    rst_b = 1'b1;
    chk("rst2_req", 32'(a_req), 32'h1);
    a_hit = 1'b1;
    a_exp_q.push_back(32'h0);
    tick();
    a_hit = 1'b0;
    tick();
    tick();

    chk("a_sb_empty", 32'(a_exp_q.size()), 32'h0);
    chk("b_sb_empty", 32'(b_exp_q.size()), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
